andromeda_capture_ctrl: RTL

- Sequences the RGB pixel capture datapath into a double-banked frame memory.
- Arms on command, aligns to frame/line strobes and generates raster x/y and linear write addresses for a WIDTH x HEIGHT frame.
- Registers the 36-bit pixel word, applies write back-pressure and swaps banks between capture and the readout engine.
- Sits between the sensor front-end (pixel/sync strobes) and the frame-buffer write port.

---
 rtl/andromeda_pkg.sv | 24 ++
 rtl/andromeda_raster_counter.sv | 63 ++++++
 rtl/andromeda_capture_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/andromeda_pkg.sv
// Shared types and constants for the Andromeda RGB capture controller.
package andromeda_pkg;

    localparam int IMAGE_WIDTH_DEF  = 720;
    localparam int IMAGE_HEIGHT_DEF = 480;
    localparam int CHAN_W           = 12;

    localparam int ERR_OVERRUN     = 0;
    localparam int ERR_LINE_LONG   = 1;
    localparam int ERR_SHORT_FRAME = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_CAPTURE
    } state_t;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } pixel_t;

endpackage

// File: rtl/andromeda_raster_counter.sv
// Raster x/y, line base and linear write address, all maintained incrementally.
module andromeda_raster_counter
    import andromeda_pkg::*;
#(
    parameter int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
    parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
    parameter int ADDR_W       = 19
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              restart,
    input  logic              new_line,
    input  logic              advance,
    output logic [9:0]        x,
    output logic [8:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic [9:0]        eff_x,
    output logic [8:0]        eff_y,
    output logic [ADDR_W-1:0] eff_addr
);

    localparam logic [8:0]        Y_END     = 9'(IMAGE_HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMAGE_WIDTH);

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] eff_base;

    // eff_* is the position the pixel of this cycle lands on, after any sync strobe
    always_comb begin
        eff_x    = x;
        eff_y    = y;
        eff_addr = addr;
        eff_base = base;
        if (restart) begin
            eff_x    = '0;
            eff_y    = '0;
            eff_addr = '0;
            eff_base = '0;
        end else if (new_line && (x != '0)) begin
            eff_x = '0;
            if (y < Y_END) begin
                eff_y    = y + 9'd1;
                eff_base = base + LINE_STEP;
            end
            eff_addr = eff_base;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
            base <= '0;
        end else begin
            x    <= advance ? eff_x + 10'd1 : eff_x;
            addr <= advance ? eff_addr + ADDR_W'(1) : eff_addr;
            y    <= eff_y;
            base <= eff_base;
        end
    end

endmodule

// File: rtl/andromeda_capture_ctrl.sv
// Capture sequencer: arms, aligns to sync strobes, registers pixel writes and
// swaps frame-memory banks with the readout engine.
module andromeda_capture_ctrl
    import andromeda_pkg::*;
#(
    parameter int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
    parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
    parameter int ADDR_W       = 19,
    parameter int PIX_W        = 36
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pixel_valid_in,
    input  logic [PIX_W-1:0]  pixel_data_in,
    input  logic              frame_start_in,
    input  logic              line_start_in,
    input  logic              cmd_arm_in,
    input  logic              cmd_continuous_in,
    input  logic              cmd_abort_in,
    input  logic              wr_ready_in,
    input  logic              rd_busy_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [PIX_W-1:0]  wr_data_out,
    output logic              wr_bank_out,
    output logic [9:0]        pixel_x_out,
    output logic [8:0]        pixel_y_out,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic [2:0]        err_out,
    output logic [7:0]        frames_dropped_out
);

    localparam logic [9:0] X_END  = 10'(IMAGE_WIDTH);
    localparam logic [9:0] X_LAST = 10'(IMAGE_WIDTH - 1);
    localparam logic [8:0] Y_END  = 9'(IMAGE_HEIGHT);
    localparam logic [8:0] Y_LAST = 9'(IMAGE_HEIGHT - 1);

    state_t state;
    state_t state_next;
    logic   cont_q;
    logic   swap_q;

    logic              restart;
    logic              new_line;
    logic              accept;
    logic              in_range;
    logic              advance;
    logic              do_write;
    logic              last;
    logic              arm_take;
    logic [2:0]        err_set;
    logic [9:0]        eff_x;
    logic [8:0]        eff_y;
    logic [ADDR_W-1:0] eff_addr;
    logic [ADDR_W-1:0] cur_addr;

    andromeda_raster_counter #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .ADDR_W       (ADDR_W)
    ) u_raster (
        .clock    (clock),
        .reset_n  (reset_n),
        .restart  (restart),
        .new_line (new_line),
        .advance  (advance),
        .x        (pixel_x_out),
        .y        (pixel_y_out),
        .addr     (cur_addr),
        .eff_x    (eff_x),
        .eff_y    (eff_y),
        .eff_addr (eff_addr)
    );

    // Abort masks every counter and write action in the same cycle
    always_comb begin
        arm_take = (state == S_IDLE) && cmd_arm_in && !cmd_abort_in;
        restart  = !cmd_abort_in && frame_start_in && (state != S_IDLE);
        new_line = !cmd_abort_in && (state == S_CAPTURE) && line_start_in && !frame_start_in;
        accept   = !cmd_abort_in && pixel_valid_in &&
                   ((state == S_CAPTURE) || ((state == S_WAIT_FRAME) && frame_start_in));
        in_range = (eff_x < X_END) && (eff_y < Y_END);
        advance  = accept && in_range;
        do_write = advance && wr_ready_in;
        last     = advance && (eff_x == X_LAST) && (eff_y == Y_LAST);
        err_set                  = '0;
        err_set[ERR_OVERRUN]     = advance && !wr_ready_in;
        err_set[ERR_LINE_LONG]   = accept && (eff_x >= X_END) && (eff_y < Y_END);
        err_set[ERR_SHORT_FRAME] = restart && (state == S_CAPTURE);
    end

    always_comb begin
        state_next = state;
        if (cmd_abort_in) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:       if (cmd_arm_in) state_next = S_WAIT_FRAME;
                S_WAIT_FRAME: if (frame_start_in) state_next = S_CAPTURE;
                S_CAPTURE:    state_next = S_CAPTURE;
                default:      state_next = S_IDLE;
            endcase
            if (last) state_next = cont_q ? S_WAIT_FRAME : S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign busy_out = (state != S_IDLE);

    // Bank toggles the cycle after frame_done so the last write still carries the old bank
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_out          <= 1'b0;
            wr_addr_out        <= '0;
            wr_data_out        <= '0;
            frame_done_out     <= 1'b0;
            swap_q             <= 1'b0;
            wr_bank_out        <= 1'b0;
            err_out            <= '0;
            frames_dropped_out <= '0;
            cont_q             <= 1'b0;
        end else begin
            wr_en_out <= do_write;
            if (do_write) begin
                wr_addr_out <= eff_addr;
                wr_data_out <= pixel_data_in;
            end
            frame_done_out <= last;
            swap_q         <= last && !rd_busy_in;
            wr_bank_out    <= wr_bank_out ^ swap_q;
            if (last && rd_busy_in && (frames_dropped_out != 8'hFF)) begin
                frames_dropped_out <= frames_dropped_out + 8'd1;
            end
            if (arm_take) begin
                cont_q  <= cmd_continuous_in;
                err_out <= '0;
            end else begin
                err_out <= err_out | err_set;
            end
        end
    end

endmodule
